// File: rtl/button_event_if.sv
// button_event_if: debounced button level in, decoded user events and press count out
interface button_event_if;
  logic       db_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       click_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic       long_held;
  logic [7:0] press_count;
  modport master (
    output db_in,
    input  press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse,
    input  held, long_held, press_count
  );
  modport slave (
    input  db_in,
    output press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse,
    output held, long_held, press_count
  );
endinterface

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release/click/long/repeat pulses (auto-repeat under BTN_AUTOREPEAT_EN)
module button_event_decoder #(
  parameter int LONG_CYCLES   = 19_000_000,
  parameter int REPEAT_CYCLES = 3_800_000,
  parameter int CNT_W         = 25
) (
  input logic          clk,
  input logic          n_reset,
  button_event_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) > (longint'(1) << CNT_W) - 1 ||
      REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_param
    $error("button_event_decoder: LONG_CYCLES/REPEAT_CYCLES out of range for CNT_W");
  end
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             db_prev;
  logic             rise, fall;
  assign rise          = bus.db_in & ~db_prev;
  assign fall          = ~bus.db_in & db_prev;
  assign bus.held      = state != IDLE;
  assign bus.long_held = state == LONG;
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`else
  assign bus.repeat_pulse = 1'b0;
`endif
  // edge history, hold/repeat timing and one-cycle event pulses
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state             <= IDLE;
      cnt               <= '0;
      db_prev           <= 1'b0;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.click_pulse   <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.press_count   <= 8'd0;
`ifdef BTN_AUTOREPEAT_EN
      bus.repeat_pulse  <= 1'b0;
`endif
    end else begin
      db_prev           <= bus.db_in;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.click_pulse   <= 1'b0;
      bus.long_pulse    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      bus.repeat_pulse  <= 1'b0;
`endif
      case (state)
        IDLE: if (rise) begin
          state           <= PRESSED;
          cnt             <= '0;
          bus.press_pulse <= 1'b1;
          bus.press_count <= bus.press_count + 8'd1;
        end
        PRESSED: if (fall) begin
          state             <= IDLE;
          bus.release_pulse <= 1'b1;
          bus.click_pulse   <= 1'b1;
        end else if (cnt == LONG_LAST) begin
          state          <= LONG;
          cnt            <= '0;
          bus.long_pulse <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        LONG: if (fall) begin
          state             <= IDLE;
          bus.release_pulse <= 1'b1;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt == REPEAT_LAST) begin
            bus.repeat_pulse <= 1'b1;
            cnt              <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: random and directed button traffic checked against an edge-count event model
module tb_button_event_decoder;
  localparam int L = 10;
  localparam int R = 4;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   m_prev, m_active;
  int   m_k;
  int   m_count;
  bit   e_press, e_rel, e_click, e_long, e_rep, e_held, e_lheld;
  button_event_if bus();
  button_event_decoder #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(8)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  // model: events follow from how many edges have passed since the press edge
  task automatic model(input bit d, input bit r);
    {e_press, e_rel, e_click, e_long, e_rep} = '0;
    if (!r) begin
      m_prev = 0; m_active = 0; m_k = 0; m_count = 0;
    end else begin
      if (!m_active && d && !m_prev) begin
        e_press = 1; m_count = (m_count + 1) % 256; m_active = 1; m_k = 0;
      end else if (m_active) begin
        m_k++;
        if (!d) begin
          e_rel = 1; e_click = m_k <= L; m_active = 0;
        end else begin
          e_long = m_k == L;
`ifdef BTN_AUTOREPEAT_EN
          e_rep = m_k > L && (m_k - L) % R == 0;
`endif
        end
      end
      m_prev = d;
    end
    e_held  = m_active;
    e_lheld = m_active && m_k >= L;
  endtask
  task automatic tick(input bit d, input bit r);
    @(negedge clk);
    bus.db_in = d;
    n_reset   = r;
    @(posedge clk);
    model(d, r);
    #1;
    check("press_pulse",   bus.press_pulse,   e_press);
    check("release_pulse", bus.release_pulse, e_rel);
    check("click_pulse",   bus.click_pulse,   e_click);
    check("long_pulse",    bus.long_pulse,    e_long);
    check("repeat_pulse",  bus.repeat_pulse,  e_rep);
    check("held",          bus.held,          e_held);
    check("long_held",     bus.long_held,     e_lheld);
    check("press_count",   bus.press_count,   m_count);
  endtask
  task automatic hold(input int n, input int gap);
    for (int i = 0; i < n; i++) tick(1, 1);
    for (int i = 0; i < gap; i++) tick(0, 1);
  endtask
  initial begin
    bus.db_in = 1'b1;
    for (int i = 0; i < 3; i++) tick(1, 0);
    tick(1, 1);
    check("reset_then_press", bus.press_pulse, 1);
    check("reset_then_count", bus.press_count, 1);
    hold(3, 3);
    hold(5, 3);
    hold(10, 3);
    hold(30, 3);
    for (int i = 0; i < 2; i++) tick(0, 0);
    for (int i = 0; i < 256; i++) hold(1, 1);
    check("count_wrap", bus.press_count, 0);
    hold(15, 0);
    check("in_long", bus.long_held, 1);
    tick(1, 0);
    check("mid_reset_held", bus.held, 0);
    tick(0, 1);
    check("mid_reset_no_release", bus.release_pulse, 0);
    for (int it = 0; it < 60; it++) begin
      int n;
      n = $urandom_range(35, 1);
      for (int i = 0; i < n; i++) tick(1, $urandom_range(19, 0) != 0);
      for (int i = 0; i < int'($urandom_range(4, 1)); i++) tick(0, 1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the clean, synchronous level from the button debouncer and turns it into single-cycle user events: press, release, short click, long press and optional auto-repeat. It sits between the debouncer output and the control logic that drives menu and mode selection. This means no consumer needs its own edge detection or hold timing. All outputs are registered and synchronous to `clk`.

## Interface
- `LONG_CYCLES`, default 19_000_000: hold time in cycles before a press is long (0.5 s at 38 MHz); legal range 2 to 2^CNT_W-1.
- `REPEAT_CYCLES`, default 3_800_000: auto-repeat period in cycles once long (100 ms); legal range 1 to 2^CNT_W-1.
- `CNT_W`, default 25: width of the hold/repeat counter.
- `clk` input 1: system clock.
- `n_reset` input 1: reset, synchronous, active-low; clock `clk`.
- `db_in` input 1: debounced button level, 1 = pressed; already synchronous to `clk`.
- `press_pulse` output 1: one cycle on each press.
- `release_pulse` output 1: one cycle on each release.
- `click_pulse` output 1: one cycle on release of a press that never became long.
- `long_pulse` output 1: one cycle when a press crosses `LONG_CYCLES`.
- `repeat_pulse` output 1: one cycle per repeat period while a long press is held.
- `held` output 1: level, 1 while in PRESSED or LONG.
- `long_held` output 1: level, 1 while in LONG.
- `press_count` output 8: running count of presses, wraps 255 -> 0.

## Operation
- The block registers `db_in` into `db_prev` every cycle.
  - rise = `db_in & ~db_prev`
  - fall = `~db_in & db_prev`
- The FSM has three states: IDLE, PRESSED and LONG. One `CNT_W` counter `cnt` serves both hold timing and repeat timing.
- IDLE:
  - On rise, the block goes to PRESSED, clears `cnt`, pulses `press_pulse` and increments `press_count`.
- PRESSED:
  - On fall, the block goes to IDLE and pulses `release_pulse` and `click_pulse`.
  - Otherwise, if `cnt == LONG_CYCLES-1`, the block goes to LONG, clears `cnt` and pulses `long_pulse`.
  - Otherwise, `cnt` increments by 1.
- LONG:
  - On fall, the block goes to IDLE and pulses `release_pulse` only.
  - Otherwise, auto-repeat runs (see Configuration).
- Priority on any single edge: a fall beats a threshold hit. A release on the same edge as `cnt == LONG_CYCLES-1` gives a click and no `long_pulse`.
- `cnt` never wraps. Its compare values always fit in `CNT_W`, and the counter is cleared on every state entry.
- `held` and `long_held` are decoded from the registered state, so they have no extra latency.

## Timing
- Reset state: every output is 0, `press_count` is 0, `db_prev` is 0, `cnt` is 0, and the state is IDLE.
- If the button is held through reset, a `press_pulse` appears on the first edge after `n_reset` goes high.
- Press latency:
  - Edge E0 is the first edge that samples `db_in=1` with `db_prev=0`.
  - `press_pulse`, `held` and the new `press_count` are valid in the cycle after E0.
- Long latency: `long_pulse` and `long_held` assert after edge E0+`LONG_CYCLES`.
- First repeat: `repeat_pulse` asserts after edge E0+`LONG_CYCLES`+`REPEAT_CYCLES`, then again every `REPEAT_CYCLES` edges.
- Release latency:
  - `release_pulse` (and `click_pulse`, if applicable) assert the cycle after the first edge that samples `db_in=0`.
  - `held` and `long_held` drop in the same cycle.
- Every pulse output is exactly one cycle wide.
- A new press may start on the edge immediately after IDLE is re-entered, so back-to-back presses need no gap cycle.
- Reset mid-operation: state, `cnt` and outputs return to reset values on that edge. No `release_pulse` is emitted.

## Configuration
- Macro: `BTN_AUTOREPEAT_EN`.
- Defined: in LONG, if `cnt == REPEAT_CYCLES-1`, the block pulses `repeat_pulse` and clears `cnt`; otherwise `cnt` increments by 1.
- Undefined: `repeat_pulse` is tied to 0, `cnt` holds in LONG, and LONG waits only for a fall. No repeat logic is synthesised.

## Test plan
- Setup for all scenarios: `LONG_CYCLES`=10, `REPEAT_CYCLES`=4, reset held 3 cycles.
- Reset: hold `n_reset`=0 with `db_in`=1 -> all outputs 0; `press_pulse` appears one cycle after `n_reset` deasserts, and `press_count`=1.
- Short click: `db_in` high for 5 cycles -> `press_pulse` after E0, then `release_pulse` and `click_pulse` together, with no `long_pulse`.
- Boundary click: `db_in` high for exactly 10 sampled edges (fall sampled at E0+10) -> click and release occur, and `long_pulse` never fires.
- Long with repeat (macro defined): hold 30 cycles -> `long_pulse` after E0+10, `repeat_pulse` after E0+14, E0+18, E0+22 and E0+26; on release, `release_pulse` fires without `click_pulse`.
- Long without repeat (macro undefined): same stimulus -> `long_pulse` once, `long_held` stays 1 until release, and `repeat_pulse` stays 0 throughout.
- Counter wrap and reset mid-press: 256 one-cycle presses separated by one idle cycle -> `press_count` returns to 0. A reset asserted while in LONG -> state IDLE and no `release_pulse`.
